// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and register-index type.
package mips_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_RA   = 5'd31;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set-over-clear,
// with hazard queries that already account for this cycle's clear.
module reg_scoreboard
  import mips_pkg::*;
(
  input  logic     clock,
  input  logic     reset_n,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t q_rs,
  input  reg_idx_t q_rt,
  input  reg_idx_t q_dest,
  input  logic     q_dest_en,
  output logic     hz_rs,
  output logic     hz_rt,
  output logic     hz_dest
);

  logic [NUM_REGS-1:0] busy_reg;

  // r0 can never be pending, so its bit is tied off rather than stored.
  assign busy_reg[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_en && (set_idx == reg_idx_t'(gi));
      assign clr_hit = clr_en && (clr_idx == reg_idx_t'(gi));

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          busy_reg[gi] <= 1'b0;
        end else if (set_hit) begin
          busy_reg[gi] <= 1'b1;
        end else if (clr_hit) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // A register being retired this very cycle no longer blocks its reader.
  assign hz_rs   = (q_rs != REG_ZERO) && busy_reg[q_rs]
                   && !(clr_en && (clr_idx == q_rs));
  assign hz_rt   = (q_rt != REG_ZERO) && busy_reg[q_rt]
                   && !(clr_en && (clr_idx == q_rt));
  assign hz_dest = q_dest_en && (q_dest != REG_ZERO) && busy_reg[q_dest]
                   && !(clr_en && (clr_idx == q_dest));

endmodule

// File: rtl/operand_fetch.sv
// Operand-read stage: RAW/WAW hazard stall, same-cycle writeback forwarding,
// and a one-deep output register toward execute.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_writes,
  input  logic              in_jal,
  input  logic [DATA_W-1:0] in_pc,
  output logic [ADDR_W-1:0] read_register1,
  output logic [ADDR_W-1:0] read_register2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic              wb_regwrite,
  input  logic              wb_jal,
  input  logic [ADDR_W-1:0] wb_write_register,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic [DATA_W-1:0] wb_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_writes,
  output logic [DATA_W-1:0] out_pc,
  output logic              stall
);

  localparam logic [ADDR_W-1:0] RA_IDX   = ADDR_W'(mips_pkg::REG_RA);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(mips_pkg::REG_ZERO);

  logic [ADDR_W-1:0] wb_eff_dest;
  logic [DATA_W-1:0] wb_eff_data;
  logic [ADDR_W-1:0] dest_eff;
  logic [DATA_W-1:0] op_a_next;
  logic [DATA_W-1:0] op_b_next;
  logic              hz_rs, hz_rt, hz_dest;
  logic              hazard;
  logic              accept;

  assign read_register1 = in_rs;
  assign read_register2 = in_rt;

  // Same resolution the bank applies on its write port.
  assign wb_eff_dest = wb_jal ? RA_IDX : wb_write_register;
  assign wb_eff_data = wb_jal ? wb_pc : wb_write_data;
  assign dest_eff    = in_jal ? RA_IDX : in_dest;

  always_comb begin
    op_a_next = read_data1;
    if (in_rs == ZERO_IDX) begin
      op_a_next = '0;
    end else if (wb_regwrite && (wb_eff_dest == in_rs)) begin
      op_a_next = wb_eff_data;
    end
  end

  always_comb begin
    op_b_next = read_data2;
    if (in_rt == ZERO_IDX) begin
      op_b_next = '0;
    end else if (wb_regwrite && (wb_eff_dest == in_rt)) begin
      op_b_next = wb_eff_data;
    end
  end

  reg_scoreboard u_scoreboard (
    .clock     (clock),
    .reset_n   (reset_n),
    .set_en    (accept && in_writes && (dest_eff != ZERO_IDX)),
    .set_idx   (dest_eff),
    .clr_en    (wb_regwrite),
    .clr_idx   (wb_eff_dest),
    .q_rs      (in_rs),
    .q_rt      (in_rt),
    .q_dest    (dest_eff),
    .q_dest_en (in_writes),
    .hz_rs     (hz_rs),
    .hz_rt     (hz_rt),
    .hz_dest   (hz_dest)
  );

  assign hazard   = hz_rs || hz_rt || hz_dest;
  assign stall    = in_valid && hazard;
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_dest   <= '0;
      out_writes <= 1'b0;
      out_pc     <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_a      <= op_a_next;
      out_b      <= op_b_next;
      out_dest   <= dest_eff;
      out_writes <= in_writes;
      out_pc     <= in_pc;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Table-driven bench for operand_fetch with a bank model, a busy-bit model
// and a queue of expected output records.
module tb_operand_fetch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_dest;
  logic        in_writes, in_jal;
  logic [31:0] in_pc;
  logic [4:0]  read_register1, read_register2;
  logic [31:0] read_data1, read_data2;
  logic        wb_regwrite, wb_jal;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_write_data, wb_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b, out_pc;
  logic [4:0]  out_dest;
  logic        out_writes, stall;

  logic [31:0] bank_m [32];
  logic        busy_m [32];
  logic        ov_m;

  assign read_data1 = bank_m[read_register1];
  assign read_data2 = bank_m[read_register2];

  always #5 clock = ~clock;

  operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_dest(in_dest),
    .in_writes(in_writes), .in_jal(in_jal), .in_pc(in_pc),
    .read_register1(read_register1), .read_register2(read_register2),
    .read_data1(read_data1), .read_data2(read_data2),
    .wb_regwrite(wb_regwrite), .wb_jal(wb_jal),
    .wb_write_register(wb_write_register), .wb_write_data(wb_write_data),
    .wb_pc(wb_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_dest(out_dest),
    .out_writes(out_writes), .out_pc(out_pc), .stall(stall)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, dest;
    logic        wr, jal;
    logic [31:0] pc;
    logic        wb, wbj;
    logic [4:0]  wbr;
    logic [31:0] wbd, wbpc;
    logic        ord;
    logic        exp_rdy, exp_stall;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, pc;
    logic [4:0]  dest;
    logic        wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic v, int rs, int rt, int dest, logic wr, logic jal,
                              logic [31:0] pc, logic wb, logic wbj, int wbr,
                              logic [31:0] wbd, logic [31:0] wbpc, logic ord,
                              logic rdy, logic stl);
    vec_t t;
    t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.dest = 5'(dest);
    t.wr = wr; t.jal = jal; t.pc = pc; t.wb = wb; t.wbj = wbj;
    t.wbr = 5'(wbr); t.wbd = wbd; t.wbpc = wbpc; t.ord = ord;
    t.exp_rdy = rdy; t.exp_stall = stl;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] op_model(input logic [4:0] idx, input vec_t t);
    logic [4:0]  eff = t.wbj ? 5'd31 : t.wbr;
    logic [31:0] dat = t.wbj ? t.wbpc : t.wbd;
    if (idx == 5'd0) return 32'h0;
    if (t.wb && eff == idx) return dat;
    return bank_m[idx];
  endfunction

  function automatic logic hz_model(input logic [4:0] idx, input vec_t t);
    logic [4:0] eff = t.wbj ? 5'd31 : t.wbr;
    return (idx != 5'd0) && busy_m[idx] && !(t.wb && eff == idx);
  endfunction

  task automatic drive(input vec_t t);
    in_valid = t.v; in_rs = t.rs; in_rt = t.rt; in_dest = t.dest;
    in_writes = t.wr; in_jal = t.jal; in_pc = t.pc;
    wb_regwrite = t.wb; wb_jal = t.wbj; wb_write_register = t.wbr;
    wb_write_data = t.wbd; wb_pc = t.wbpc; out_ready = t.ord;
  endtask

  // Called right after a falling edge; returns at the next falling edge.
  task automatic apply(input vec_t t, input string tag);
    logic [4:0] dst;
    logic [4:0] eff;
    logic       haz, rdy_m, acc;
    exp_t       e;
    drive(t);
    #2;
    dst   = t.jal ? 5'd31 : t.dest;
    eff   = t.wbj ? 5'd31 : t.wbr;
    haz   = hz_model(t.rs, t) || hz_model(t.rt, t) || (t.wr && hz_model(dst, t));
    rdy_m = !haz && (!ov_m || t.ord);
    acc   = t.v && rdy_m;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(t.exp_rdy));
    chk({tag, ".stall"}, 32'(stall), 32'(t.exp_stall));
    chk({tag, ".ready_model"}, 32'(in_ready), 32'(rdy_m));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov_m));
    if (ov_m) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".queue_nonempty"}, 32'd0, 32'd1);
      end else begin
        chk({tag, ".out_a"}, out_a, exp_q[0].a);
        chk({tag, ".out_b"}, out_b, exp_q[0].b);
        chk({tag, ".out_dest"}, 32'(out_dest), 32'(exp_q[0].dest));
        chk({tag, ".out_writes"}, 32'(out_writes), 32'(exp_q[0].wr));
        chk({tag, ".out_pc"}, out_pc, exp_q[0].pc);
        if (t.ord) void'(exp_q.pop_front());
      end
    end
    if (acc) begin
      e.a = op_model(t.rs, t); e.b = op_model(t.rt, t);
      e.dest = dst; e.wr = t.wr; e.pc = t.pc;
      exp_q.push_back(e);
    end
    $display("%s: v=%0b rs=%0d rt=%0d dest=%0d wr=%0b jal=%0b wb=%0b ord=%0b -> rdy=%0b stall=%0b acc=%0b",
             tag, t.v, t.rs, t.rt, dst, t.wr, t.jal, t.wb, t.ord, in_ready, stall, acc);
    @(posedge clock);
    if (t.wb) begin
      busy_m[eff] = 1'b0;
      if (eff != 5'd0) bank_m[eff] = t.wbj ? t.wbpc : t.wbd;
    end
    if (acc && t.wr && dst != 5'd0) busy_m[dst] = 1'b1;
    if (acc) ov_m = 1'b1;
    else if (t.ord) ov_m = 1'b0;
    @(negedge clock);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    ov_m = 1'b0;
    exp_q.delete();
  endtask

  vec_t vecs[23];
  vec_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) bank_m[i] = 32'h100 * i;
    bank_m[0] = 32'hFFFF_FFFF; bank_m[8] = 32'h11; bank_m[9] = 32'h22;
    bank_m[31] = 32'h1F1F;
    model_reset();
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    //             v rs rt ds wr jl pc        wb wj wr wbd            wbpc     ord rdy stl
    vecs[0]  = idle;
    vecs[1]  = mk(1, 8, 9, 0, 0, 0, 32'h100, 0, 0, 0, 0,             0,       1, 1, 0);
    vecs[2]  = mk(1, 0, 0, 5, 1, 0, 32'h104, 0, 0, 0, 0,             0,       1, 1, 0);
    vecs[3]  = mk(1, 5, 9, 0, 0, 0, 32'h108, 0, 0, 0, 0,             0,       1, 0, 1);
    vecs[4]  = vecs[3];
    vecs[5]  = mk(1, 5, 9, 0, 0, 0, 32'h108, 1, 0, 5, 32'hDEAD0000,  0,       1, 1, 0);
    vecs[6]  = mk(1, 0, 0, 3, 1, 1, 32'h10C, 0, 0, 0, 0,             0,       1, 1, 0);
    vecs[7]  = mk(1, 31, 8, 0, 0, 0, 32'h110, 0, 0, 0, 0,            0,       1, 0, 1);
    vecs[8]  = mk(1, 31, 8, 0, 0, 0, 32'h110, 1, 1, 7, 32'h999,      32'h40,  1, 1, 0);
    vecs[9]  = mk(1, 31, 0, 0, 0, 0, 32'h114, 0, 0, 0, 0,            0,       1, 1, 0);
    vecs[10] = mk(1, 8, 9, 0, 0, 0, 32'h200, 0, 0, 0, 0,             0,       0, 0, 0);
    vecs[11] = vecs[10];
    vecs[12] = vecs[10];
    vecs[13] = mk(1, 8, 9, 0, 0, 0, 32'h200, 0, 0, 0, 0,             0,       1, 1, 0);
    vecs[14] = mk(1, 0, 0, 0, 1, 0, 32'h300, 0, 0, 0, 0,             0,       1, 1, 0);
    vecs[15] = mk(1, 0, 0, 0, 1, 0, 32'h304, 0, 0, 0, 0,             0,       1, 1, 0);
    vecs[16] = mk(1, 0, 0, 9, 1, 0, 32'h308, 0, 0, 0, 0,             0,       1, 1, 0);
    vecs[17] = mk(1, 0, 0, 9, 1, 0, 32'h30C, 0, 0, 0, 0,             0,       1, 0, 1);
    vecs[18] = mk(1, 0, 0, 9, 1, 0, 32'h30C, 1, 0, 9, 32'h77,        0,       1, 1, 0);
    vecs[19] = mk(1, 9, 0, 0, 0, 0, 32'h310, 0, 0, 0, 0,             0,       1, 0, 1);
    vecs[20] = mk(1, 9, 0, 0, 0, 0, 32'h310, 1, 0, 9, 32'h88,        0,       1, 1, 0);
    vecs[21] = mk(1, 0, 8, 0, 0, 0, 32'h314, 1, 0, 0, 32'h1234,      0,       1, 1, 0);
    vecs[22] = idle;

    reset_n = 1'b0;
    drive(idle);
    repeat (2) @(negedge clock);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_a", out_a, 32'd0);
    chk("reset.out_b", out_b, 32'd0);
    chk("reset.out_pc", out_pc, 32'd0);
    chk("reset.out_dest", 32'(out_dest), 32'd0);
    chk("reset.out_writes", 32'(out_writes), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 23; i++) apply(vecs[i], $sformatf("vec%0d", i));
    chk("drain.queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bank.r0_untouched", bank_m[0], 32'hFFFF_FFFF);

    // Reset while a reader of r12 is stalled behind a pending write.
    apply(mk(1, 0, 0, 12, 1, 0, 32'h400, 0, 0, 0, 0, 0, 1, 1, 0), "rst.set12");
    drive(mk(1, 12, 0, 0, 0, 0, 32'h404, 0, 0, 0, 0, 0, 1, 0, 1));
    #2;
    chk("rst.pre_stall", 32'(stall), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst.async_out_valid", 32'(out_valid), 32'd0);
    chk("rst.async_out_a", out_a, 32'd0);
    chk("rst.async_out_dest", 32'(out_dest), 32'd0);
    chk("rst.async_stall", 32'(stall), 32'd0);
    chk("rst.async_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    apply(mk(1, 12, 0, 0, 0, 0, 32'h404, 0, 0, 0, 0, 0, 1, 1, 0), "rst.reader12");
    apply(idle, "rst.drain");
    chk("rst.queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-read stage of the MIPS pipeline: the read-side counterpart of the register bank. It accepts decoded instructions over a valid/ready handshake and drives the bank's two read addresses. It resolves read-after-write hazards against outstanding writes with a 32-entry pending-write scoreboard, forwarding writeback data when a write lands in the same cycle. It presents both operands in a one-deep output pipeline register to the execute stage.

## Interface

Parameters:
- `DATA_W`, 32, register/operand width
- `ADDR_W`, 5, register index width

Ports:
- `clock`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage accepts instruction this cycle
- `in_rs`, `in_rt`  in  ADDR_W  source register indices
- `in_dest`  in  ADDR_W  destination index (ignored when `in_jal`=1)
- `in_writes`  in  1  instruction writes a register
- `in_jal`  in  1  instruction is JAL; destination forced to 31
- `in_pc`  in  DATA_W  instruction PC
- `read_register1`, `read_register2`  out  ADDR_W  bank read addresses (combinational = `in_rs`/`in_rt`)
- `read_data1`, `read_data2`  in  DATA_W  bank read data
- `wb_regwrite`  in  1  writeback commits this cycle
- `wb_jal`  in  1  writeback is a JAL link write
- `wb_write_register`  in  ADDR_W  writeback destination
- `wb_write_data`  in  DATA_W  writeback data (non-JAL)
- `wb_pc`  in  DATA_W  link value written to r31 when `wb_jal`=1
- `out_valid`  out  1  operands valid
- `out_ready`  in  1  execute accepts
- `out_a`, `out_b`  out  DATA_W  operands for rs, rt
- `out_dest`  out  ADDR_W  resolved destination (31 for JAL)
- `out_writes`, `out_pc`  out  1/DATA_W  passed through
- `stall`  out  1  hazard is blocking a valid input

## Operation

- Effective writeback: `wb_eff_dest` = `wb_jal` ? 31 : `wb_write_register`; `wb_eff_data` = `wb_jal` ? `wb_pc` : `wb_write_data`. This mirrors bank write semantics exactly.
- Operand select per source: index 0 → 0, regardless of bank contents. Otherwise, if `wb_regwrite` and `wb_eff_dest` == index → `wb_eff_data`. Otherwise → bank read data.
- Hazard: the source or resolved destination (if `in_writes`) is nonzero, busy, and not cleared by this cycle's writeback. WAW stalls as well, so at most one write is outstanding per register.
- `stall` = `in_valid` & hazard. `in_ready` = !hazard & (!`out_valid` | `out_ready`).
- Accept (`in_valid` & `in_ready`):
  - output register loads the operands, `out_dest`, `out_writes` and `out_pc`, and `out_valid` is set to 1;
  - if `in_writes` and the resolved dest ≠ 0, the busy bit for that dest is set.
- Otherwise, if `out_ready`, `out_valid` clears and data holds.
- Scoreboard clear: `wb_regwrite` clears busy[`wb_eff_dest`]. When a set and a clear hit the same register in the same cycle, the set wins.
- Writes to r0 never set busy. A writeback to r0 is a no-op.

## Timing

- Reset (async assert, sync-safe deassert): `out_valid`=0; `out_a`, `out_b`, `out_pc`=0; `out_dest`=0; `out_writes`=0; all busy bits 0.
- Latency: an instruction accepted in cycle N has `out_valid`=1 in N+1.
- Throughput: one instruction per cycle when there are no hazards and `out_ready`=1.
- While `out_valid` & !`out_ready`, all `out_*` hold stable.
- A stalled source whose writeback arrives in cycle M is accepted in M with forwarded data, giving zero bubble.
- Reset asserted mid-stall or mid-transfer drops the in-flight instruction and clears the scoreboard.

## Structure

- Shared package `mips_pkg`: `REG_ZERO`=0, `REG_RA`=31, `DATA_W`, `ADDR_W`, and a `reg_idx_t` typedef.
- Sub-module `reg_scoreboard`:
  - 32 busy bits with set/clear ports;
  - two source-hazard query ports and one destination-hazard query port;
  - set-over-clear priority.
- Forwarding mux and output register live in `operand_fetch`.

## Test plan

- Reset → `out_valid`=0, `in_ready`=1, all `out_*`=0, busy all 0.
- Bank r8=0x11, r9=0x22; issue rs=8, rt=9 → next cycle `out_a`=0x11, `out_b`=0x22, `out_valid`=1.
- Issue write to r5, then an instruction reading r5 → `stall`=1 and `in_ready`=0 until `wb_write_register`=5 with data 0xDEAD0000. Accepted that cycle with `out_a`=0xDEAD0000.
- Issue JAL (`in_dest`=3) → `out_dest`=31, busy[31] set. A reader of r31 stalls until writeback with `wb_jal`=1 and `wb_pc`=0x40. Forwarded `out_a`=0x40, busy[31] clear.
- `out_ready`=0 for 3 cycles with `out_valid`=1 → `out_*` unchanged, `in_ready`=0; release → next instruction loads.
- Bank returns 0xFFFFFFFF for r0; rs=0 → `out_a`=0. Issue write to r0 → no busy set, and a following r0 reader does not stall.
